// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 scan controller: segment font, blank pattern
// and a width helper used to size the slot and digit counters.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry 0 is the lowest slice.
   localparam logic [15:0][6:0] FONT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h58, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned w = v - 1; w > 0; w = w >> 1)
         r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module seg7_font
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb seg = FONT[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-aligned
// double-buffered loads. Define SEG7_DIM_EN to build BRIGHT PWM dimming.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned DIGIT_CYCLES = 12500
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [4*DIGITS-1:0]   DATA_IN,
   input  logic [DIGITS-1:0]     DP_IN,
   input  logic [DIGITS-1:0]     BLANK_IN,
   input  logic                  LOAD_VALID,
   output logic                  LOAD_READY,
   input  logic                  LZS,
   input  logic [3:0]            BRIGHT,
   output logic [6:0]            SEG,
   output logic                  DP,
   output logic [DIGITS-1:0]     SEG_AN,
   output logic                  FRAME_DONE
);

   localparam int unsigned CW = clog2(DIGIT_CYCLES);
   localparam int unsigned IW = clog2(DIGITS);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   act_data, pend_data;
   logic [DIGITS-1:0]     act_dp, act_blank, pend_dp, pend_blank;
   logic                  act_lzs, pend_full, ready_q;
   logic                  cnt_end, frame_end, xfer;
   logic [DIGITS-1:0]     lead_zero;
   logic [3:0]            nib;
   logic [6:0]            font_seg;
   logic                  dark, an_on;

   always_comb begin
      cnt_end   = (cnt == CW'(DIGIT_CYCLES - 1));
      frame_end = cnt_end && (idx == IW'(DIGITS - 1));
      xfer      = LOAD_VALID && ready_q;
   end

   assign LOAD_READY = ready_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt        <= '0;
         idx        <= '0;
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         act_lzs    <= 1'b0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_full  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         cnt <= cnt_end ? '0 : cnt + CW'(1);
         if (cnt_end)
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         // A load landing on the boundary bypasses pending entirely.
         if (frame_end) begin
            pend_full <= 1'b0;
            ready_q   <= 1'b1;
            act_lzs   <= LZS;
            if (xfer) begin
               act_data  <= DATA_IN;
               act_dp    <= DP_IN;
               act_blank <= BLANK_IN;
            end else if (pend_full) begin
               act_data  <= pend_data;
               act_dp    <= pend_dp;
               act_blank <= pend_blank;
            end
         end else if (xfer) begin
            pend_data  <= DATA_IN;
            pend_dp    <= DP_IN;
            pend_blank <= BLANK_IN;
            pend_full  <= 1'b1;
            ready_q    <= 1'b0;
         end else begin
            ready_q <= ~pend_full;
         end
      end
   end

   // lead_zero[i]: nibbles i..DIGITS-1 are all zero with DP clear.
   always_comb begin
      logic run;
      run       = 1'b1;
      lead_zero = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         run = run & (act_data[4*(DIGITS-1-k) +: 4] == 4'h0) & ~act_dp[DIGITS-1-k];
         lead_zero[DIGITS-1-k] = run;
      end
   end

   always_comb begin
      nib  = act_data[{idx, 2'b00} +: 4];
      dark = act_blank[idx] | (act_lzs & (idx != '0) & lead_zero[idx]);
   end

   seg7_font u_font (
      .nib (nib),
      .seg (font_seg)
   );

`ifdef SEG7_DIM_EN
   localparam int unsigned SUB_LEN = DIGIT_CYCLES / 16;

   logic [3:0]    bright_q;
   logic [CW-1:0] sub_w;
   logic [3:0]    sub;

   always_ff @(posedge CLK) begin
      if (RST)
         bright_q <= '1;
      else if (cnt == '0)
         bright_q <= BRIGHT;
   end

   always_comb begin
      sub_w = cnt / CW'(SUB_LEN);
      sub   = (sub_w > CW'(15)) ? 4'hF : sub_w[3:0];
      an_on = (sub <= bright_q);
   end
`else
   logic unused_bright;
   assign unused_bright = ^BRIGHT;
   always_comb an_on = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         SEG        <= SEG_BLANK;
         DP         <= 1'b1;
         SEG_AN     <= '1;
         FRAME_DONE <= 1'b0;
      end else begin
         SEG        <= dark ? SEG_BLANK : font_seg;
         DP         <= dark | ~act_dp[idx];
         SEG_AN     <= an_on ? ~({{(DIGITS-1){1'b0}}, 1'b1} << idx) : '1;
         FRAME_DONE <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIGITS=4, DIGIT_CYCLES=32); honours SEG7_DIM_EN.
module tb_seg7_scan_ctrl;

   localparam int D  = 4;
   localparam int DC = 32;
   localparam int FP = D * DC;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] DATA_IN;
   logic [3:0]  DP_IN, BLANK_IN;
   logic        LOAD_VALID, LOAD_READY, LZS;
   logic [3:0]  BRIGHT;
   logic [6:0]  SEG;
   logic        DP;
   logic [3:0]  SEG_AN;
   logic        FRAME_DONE;

   int checks = 0;
   int errors = 0;
   int e;

   seg7_scan_ctrl #(.DIGITS(D), .DIGIT_CYCLES(DC)) dut (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
      .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY), .LZS(LZS), .BRIGHT(BRIGHT),
      .SEG(SEG), .DP(DP), .SEG_AN(SEG_AN), .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Reference model: display position derived from elapsed cycles since release.
   logic [6:0]  font_m [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          n, bright_m;
   logic [15:0] a_d, p_d;
   logic [3:0]  a_p, a_b, p_p, p_b;
   logic        a_l, p_full, rdy_m;
   logic [6:0]  x_seg;
   logic        x_dp, x_fd;
   logic [3:0]  x_an;
   logic        mon_en = 1'b0;

   initial begin
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            check("seg", {9'd0, SEG}, {9'd0, x_seg});
            check("dp", {15'd0, DP}, {15'd0, x_dp});
            check("an", {12'd0, SEG_AN}, {12'd0, x_an});
            check("ready", {15'd0, LOAD_READY}, {15'd0, rdy_m});
            check("frame_done", {15'd0, FRAME_DONE}, {15'd0, x_fd});
         end
         if (RST) begin
            mon_en = 1'b1;
            n = 0; a_d = 16'h0; a_p = 4'h0; a_b = 4'hF; a_l = 1'b0;
            p_full = 1'b0; rdy_m = 1'b0; bright_m = 15;
            x_seg = 7'h7F; x_dp = 1'b1; x_an = 4'hF; x_fd = 1'b0;
         end else if (mon_en) begin
            int c, di, nb;
            logic zero_above, dark, on, bnd, xf;
            c   = n % DC;
            di  = (n / DC) % D;
            bnd = ((n % FP) == FP - 1);
`ifdef SEG7_DIM_EN
            if (c == 0) bright_m = int'(BRIGHT);
            on = ((c / (DC / 16)) <= bright_m);
`else
            on = 1'b1;
`endif
            zero_above = 1'b1;
            for (int j = di; j < D; j++)
               if (((a_d >> (4 * j)) & 16'hF) != 0 || a_p[j]) zero_above = 1'b0;
            dark  = a_b[di] || (a_l && di > 0 && zero_above);
            nb    = int'((a_d >> (4 * di)) & 16'hF);
            x_seg = dark ? 7'h7F : font_m[nb];
            x_dp  = dark ? 1'b1 : ~a_p[di];
            x_an  = on ? ~(4'b0001 << di) : 4'hF;
            x_fd  = bnd;
            xf    = LOAD_VALID && rdy_m;
            if (bnd) begin
               if (xf) begin
                  a_d = DATA_IN; a_p = DP_IN; a_b = BLANK_IN;
               end else if (p_full) begin
                  a_d = p_d; a_p = p_p; a_b = p_b;
               end
               a_l = LZS; p_full = 1'b0; rdy_m = 1'b1;
            end else if (xf) begin
               p_d = DATA_IN; p_p = DP_IN; p_b = BLANK_IN; p_full = 1'b1; rdy_m = 1'b0;
            end else begin
               rdy_m = ~p_full;
            end
            n++;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      e++;
   endtask

   task automatic goto(input int t);
      while (e < t) tick();
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] dp);
      DATA_IN = d; DP_IN = dp; BLANK_IN = 4'h0; LOAD_VALID = 1'b1;
      tick();
      LOAD_VALID = 1'b0;
   endtask

   initial begin
      int lows;
      RST = 1'b1; DATA_IN = '0; DP_IN = '0; BLANK_IN = '0;
      LOAD_VALID = 1'b0; LZS = 1'b0; BRIGHT = 4'hF; e = 0;
      repeat (3) tick();
      check("rst_an", {12'd0, SEG_AN}, 16'h000F);
      check("rst_ready", {15'd0, LOAD_READY}, 16'h0000);
      RST = 1'b0; e = 0;
      check("rel1_an", {12'd0, SEG_AN}, 16'h000F);
      tick();
      check("rel2_an", {12'd0, SEG_AN}, 16'h000E);
      check("rel2_ready", {15'd0, LOAD_READY}, 16'h0001);
      goto(33);
      check("slot1_an", {12'd0, SEG_AN}, 16'h000D);
      goto(127);
      check("fd_before", {15'd0, FRAME_DONE}, 16'h0000);
      tick();
      check("fd_pulse", {15'd0, FRAME_DONE}, 16'h0001);

      goto(140);
      load(16'h12AF, 4'b0010);
      check("load_ready_drop", {15'd0, LOAD_READY}, 16'h0000);
      goto(257);
      check("f_dig0_seg", {9'd0, SEG}, 16'h000E);
      check("f_dig0_an", {12'd0, SEG_AN}, 16'h000E);
      check("f_ready_back", {15'd0, LOAD_READY}, 16'h0001);
      goto(289);
      check("f_dig1_seg", {9'd0, SEG}, 16'h0008);
      check("f_dig1_dp", {15'd0, DP}, 16'h0000);
      goto(321);
      check("f_dig2_seg", {9'd0, SEG}, 16'h0024);
      goto(353);
      check("f_dig3_seg", {9'd0, SEG}, 16'h0079);

      goto(370);
      load(16'h4444, 4'h0);
      DATA_IN = 16'h5555; LOAD_VALID = 1'b1;
      goto(380);
      LOAD_VALID = 1'b0;
      goto(385);
      check("pend_keep_first", {9'd0, SEG}, 16'h0019);

      goto(511);
      load(16'h0007, 4'h0);
      check("bnd_ready_e512", {15'd0, LOAD_READY}, 16'h0001);
      tick();
      check("bnd_direct_seg", {9'd0, SEG}, 16'h0058);
      check("bnd_ready_e513", {15'd0, LOAD_READY}, 16'h0001);

      goto(520);
      LZS = 1'b1;
      load(16'h0050, 4'h0);
      goto(641);
      check("lzs_dig0", {9'd0, SEG}, 16'h0040);
      goto(673);
      check("lzs_dig1", {9'd0, SEG}, 16'h0012);
      goto(705);
      check("lzs_dig2", {9'd0, SEG}, 16'h007F);
      goto(737);
      check("lzs_dig3", {9'd0, SEG}, 16'h007F);
      check("lzs_dig3_an", {12'd0, SEG_AN}, 16'h0007);
      goto(750);
      load(16'h0000, 4'h0);
      goto(769);
      check("lzs0_dig0", {9'd0, SEG}, 16'h0040);
      goto(801);
      check("lzs0_dig1", {9'd0, SEG}, 16'h007F);

      goto(850);
      BRIGHT = 4'd3;
      goto(896);
      lows = 0;
      repeat (FP) begin
         tick();
         if (SEG_AN[1] == 1'b0) lows++;
      end
`ifdef SEG7_DIM_EN
      check("dim3_lows", 16'(lows), 16'd8);
`else
      check("dim3_lows", 16'(lows), 16'd32);
`endif
      BRIGHT = 4'd15;
      lows = 0;
      repeat (FP) begin
         tick();
         if (SEG_AN[1] == 1'b0) lows++;
      end
      check("dim15_lows", 16'(lows), 16'd32);

      goto(1160);
      load(16'h9999, 4'h0);
      goto(1220);
      RST = 1'b1;
      tick();
      check("mrst_an", {12'd0, SEG_AN}, 16'h000F);
      check("mrst_seg", {9'd0, SEG}, 16'h007F);
      check("mrst_dp", {15'd0, DP}, 16'h0001);
      check("mrst_ready", {15'd0, LOAD_READY}, 16'h0000);
      check("mrst_fd", {15'd0, FRAME_DONE}, 16'h0000);
      repeat (2) tick();
      RST = 1'b0; e = 0;
      tick();
      check("post_an", {12'd0, SEG_AN}, 16'h000E);
      check("post_seg", {9'd0, SEG}, 16'h007F);
      goto(257);
      check("post_lost_seg", {9'd0, SEG}, 16'h007F);
      check("post_ready", {15'd0, LOAD_READY}, 16'h0001);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
